// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath controller and alu_seq.
// master drives the request side, slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output start, a, b, op, shamt,
    input  busy, done, result, flags, illegal
  );

  modport slave (
    input  start, a, b, op, shamt,
    output busy, done, result, flags, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/compare/add ops, bit-serial shifter and
// shift-add multiplier behind a start/busy/done handshake.
//   state    | meaning
//   ST_IDLE  | waiting for start; single-cycle ops finish here
//   ST_SHIFT | one bit of shift per cycle, cnt = shifts remaining
//   ST_MUL   | one shift-add step per cycle, cnt = steps remaining
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_NOTA = 4'h0, OP_NOTB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR  = 4'h4, OP_XNOR = 4'h5, OP_LTU = 4'h6, OP_GTU = 4'h7,
                         OP_LSL  = 4'h8, OP_LSR  = 4'h9, OP_ASR = 4'hA, OP_ADD = 4'hB,
                         OP_SUB  = 4'hC, OP_MULL = 4'hD, OP_MULH = 4'hE, OP_ILL = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_t;

  state_t             state, state_nxt;
  logic [3:0]         op_q, op_nxt;
  logic [WIDTH-1:0]   a_q, a_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic               done_q, done_nxt;
  logic [WIDTH-1:0]   result_q, result_nxt;
  logic [3:0]         flags_q, flags_nxt;
  logic               illegal_q, illegal_nxt;

  logic [SHW-1:0]     shamt_in;
  logic [WIDTH:0]     add_sum, sub_sum, mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0]   shift_val;
  logic               shift_out;
  logic               fin, fin_c, fin_v, fin_ill;
  logic [WIDTH-1:0]   fin_r;

  assign shamt_in    = bus.shamt;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.flags   = flags_q;
  assign bus.illegal = illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      work      <= '0;
      cnt       <= '0;
      acc       <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      a_q       <= a_nxt;
      work      <= work_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      done_q    <= done_nxt;
      result_q  <= result_nxt;
      flags_q   <= flags_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    a_nxt       = a_q;
    work_nxt    = work;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    done_nxt    = 1'b0;
    result_nxt  = result_q;
    flags_nxt   = flags_q;
    illegal_nxt = illegal_q;
    fin         = 1'b0;
    fin_r       = '0;
    fin_c       = 1'b0;
    fin_v       = 1'b0;
    fin_ill     = 1'b0;

    add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    mul_acc = {mul_sum, acc[WIDTH-1:1]};

    case (op_q)
      OP_LSL: begin
        shift_val = {work[WIDTH-2:0], 1'b0};
        shift_out = work[WIDTH-1];
      end
      OP_ASR: begin
        shift_val = {work[WIDTH-1], work[WIDTH-1:1]};
        shift_out = work[0];
      end
      default: begin
        shift_val = {1'b0, work[WIDTH-1:1]};
        shift_out = work[0];
      end
    endcase

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          op_nxt = bus.op;
          a_nxt  = bus.a;
          case (bus.op)
            OP_NOTA: begin fin = 1'b1; fin_r = ~bus.a;            end
            OP_NOTB: begin fin = 1'b1; fin_r = ~bus.b;            end
            OP_AND:  begin fin = 1'b1; fin_r = bus.a & bus.b;     end
            OP_OR:   begin fin = 1'b1; fin_r = bus.a | bus.b;     end
            OP_XOR:  begin fin = 1'b1; fin_r = bus.a ^ bus.b;     end
            OP_XNOR: begin fin = 1'b1; fin_r = ~(bus.a ^ bus.b);  end
            OP_LTU:  begin fin = 1'b1; fin_r = WIDTH'(bus.a < bus.b); end
            OP_GTU:  begin fin = 1'b1; fin_r = WIDTH'(bus.a > bus.b); end
            OP_LSL, OP_LSR, OP_ASR: begin
              if (shamt_in == '0) begin
                fin   = 1'b1;
                fin_r = bus.b;
              end else begin
                work_nxt  = bus.b;
                cnt_nxt   = CW'(shamt_in);
                state_nxt = ST_SHIFT;
              end
            end
            OP_ADD: begin
              fin   = 1'b1;
              fin_r = add_sum[WIDTH-1:0];
              fin_c = add_sum[WIDTH];
              fin_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
              fin   = 1'b1;
              fin_r = sub_sum[WIDTH-1:0];
              fin_c = sub_sum[WIDTH];
              fin_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (sub_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MULL, OP_MULH: begin
              acc_nxt   = {{WIDTH{1'b0}}, bus.b};
              cnt_nxt   = CW'(WIDTH);
              state_nxt = ST_MUL;
            end
            default: begin
              fin     = 1'b1;
              fin_ill = (bus.op == OP_ILL);
            end
          endcase
        end
      end
      ST_SHIFT: begin
        work_nxt = shift_val;
        cnt_nxt  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          fin       = 1'b1;
          fin_r     = shift_val;
          fin_c     = shift_out;
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_nxt = mul_acc;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          fin       = 1'b1;
          state_nxt = ST_IDLE;
          if (op_q == OP_MULH) begin
            fin_r = mul_acc[2*WIDTH-1:WIDTH];
            fin_c = |mul_acc[WIDTH-1:0];
          end else begin
            fin_r = mul_acc[WIDTH-1:0];
            fin_c = |mul_acc[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The reserved opcode reports a cleared result with all flags forced low.
    if (fin) begin
      done_nxt    = 1'b1;
      result_nxt  = fin_r;
      illegal_nxt = fin_ill;
      flags_nxt   = fin_ill ? 4'b0000 : {fin_r[WIDTH-1], (fin_r == '0), fin_c, fin_v};
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with an arithmetic reference model and
// directed handshake, abort and boundary cases.
module tb_alu_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();
  alu_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic [31:0] r, output logic [3:0] f,
                       output logic ill, output int lat);
    longint unsigned ua, ub, p;
    longint          sa, sb, sr;
    logic            c, v;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1; r = '0;
    case (op)
      4'h0: r = ~a;
      4'h1: r = ~b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a ^ b);
      4'h6: r = (a < b) ? 32'd1 : 32'd0;
      4'h7: r = (a > b) ? 32'd1 : 32'd0;
      4'h8: begin r = b << sh;            c = (sh != 0) ? b[32 - int'(sh)] : 1'b0; lat = 1 + int'(sh); end
      4'h9: begin r = b >> sh;            c = (sh != 0) ? b[int'(sh) - 1] : 1'b0;  lat = 1 + int'(sh); end
      4'hA: begin r = $signed(b) >>> sh;  c = (sh != 0) ? b[int'(sh) - 1] : 1'b0;  lat = 1 + int'(sh); end
      4'hB: begin
        p = ua + ub; r = p[31:0]; c = p[32];
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'hC: begin
        r = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'hD: begin p = ua * ub; r = p[31:0];  c = (p[63:32] != 0); lat = 1 + WIDTH; end
      4'hE: begin p = ua * ub; r = p[63:32]; c = (p[31:0] != 0);  lat = 1 + WIDTH; end
      default: ill = 1'b1;
    endcase
    f = ill ? 4'b0000 : {r[31], (r == 0), c, v};
  endtask

  // Call at a negedge; inputs are scrambled right after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.shamt = sh;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    bus.op = 4'($urandom); bus.shamt = 5'($urandom);
  endtask

  task automatic expect_done(input string tag, input logic [31:0] er, input logic [3:0] ef,
                             input logic ei, input int lat, input int poke_at);
    int   n = 0;
    bit   seen = 1'b0;
    bit   busy_ok = 1'b1;
    while (n < lat + 4 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (!seen && n == poke_at) begin
        bus.start = 1'b1; bus.op = 4'h0; bus.a = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    check_eq({tag, ":latency"}, 64'(n), 64'(lat));
    check_eq({tag, ":busy"}, {62'b0, busy_ok, bus.busy}, 64'b10);
    check_eq({tag, ":result"}, {32'b0, bus.result}, {32'b0, er});
    check_eq({tag, ":flags"}, {60'b0, bus.flags}, {60'b0, ef});
    check_eq({tag, ":illegal"}, {63'b0, bus.illegal}, {63'b0, ei});
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input int poke_at);
    logic [31:0] r;
    logic [3:0]  f;
    logic        ill;
    int          lat;
    model(op, a, b, sh, r, f, ill, lat);
    issue(op, a, b, sh);
    expect_done(tag, r, f, ill, lat, poke_at);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int quiet_done;
    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst:busy",    {63'b0, bus.busy},    64'd0);
    check_eq("rst:done",    {63'b0, bus.done},    64'd0);
    check_eq("rst:result",  {32'b0, bus.result},  64'd0);
    check_eq("rst:flags",   {60'b0, bus.flags},   64'd0);
    check_eq("rst:illegal", {63'b0, bus.illegal}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op("add", 4'hB, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0);
    check_eq("add:plan", {28'b0, bus.flags, bus.result}, {28'b0, 4'b0110, 32'h0000_0000});
    @(negedge clk);
    do_op("sub", 4'hC, 32'h8000_0000, 32'h0000_0001, 5'd0, 0);
    check_eq("sub:plan", {28'b0, bus.flags, bus.result}, {28'b0, 4'b0011, 32'h7FFF_FFFF});
    @(negedge clk);
    do_op("asr4", 4'hA, 32'h0, 32'h8000_0001, 5'd4, 0);
    check_eq("asr4:plan", {28'b0, bus.flags, bus.result}, {28'b0, 4'b1000, 32'hF800_0000});
    @(negedge clk);
    do_op("asr0", 4'hA, 32'h0, 32'h8000_0001, 5'd0, 0);
    check_eq("asr0:plan", {32'b0, bus.result}, {32'b0, 32'h8000_0001});
    @(negedge clk);

    do_op("mull_poke", 4'hD, 32'h0001_0000, 32'h0001_0000, 5'd0, 5);
    check_eq("mull:plan", {28'b0, bus.flags, bus.result}, {28'b0, 4'b0110, 32'h0});
    do_op("mulh", 4'hE, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
    check_eq("mulh:plan", {28'b0, bus.flags, bus.result}, {28'b0, 4'b0000, 32'h1});
    do_op("b2b_xor", 4'h4, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, 0);
    check_eq("b2b_xor:plan", {32'b0, bus.result}, {32'b0, 32'h0F0F_F0F0});
    @(negedge clk);
    check_eq("done_pulse", {63'b0, bus.done}, 64'd0);
    check_eq("result_hold", {32'b0, bus.result}, {32'b0, 32'h0F0F_F0F0});

    issue(4'hD, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort:busy",   {63'b0, bus.busy},   64'd0);
    check_eq("abort:result", {32'b0, bus.result}, 64'd0);
    quiet_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet_done++;
    end
    check_eq("abort:no_done", 64'(quiet_done), 64'd0);
    do_op("post_abort_add", 4'hB, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    check_eq("post_abort_add:plan", {28'b0, bus.flags, bus.result}, {28'b0, 4'b1001, 32'h8000_0000});
    @(negedge clk);

    do_op("illegal", 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 0);
    do_op("after_illegal", 4'h2, 32'hFFFF_FFFF, 32'h0000_00FF, 5'd0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      do_op($sformatf("rnd%0d_op%0h", i, op), op, pick_operand(), pick_operand(),
            5'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check_eq($sformatf("rnd%0d:idle_done", i), {63'b0, bus.done}, 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
